// File: rtl/data_intf_rx_buffer_if.sv
// data_intf channel: a free-running producer presents one 16-bit beat per
// cycle whenever valid is high. There is no backpressure signal.
//   valid : beat present this cycle
//   data  : beat payload, meaningful only while valid is high
// Modports: master drives the channel, slave samples it.
interface data_intf;
  logic        valid;
  logic [15:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/data_intf_rx_buffer.sv
// Receive-side buffer for the data_intf channel. Every beat the producer
// presents is written into a small circular FIFO and re-presented downstream
// on a valid/ready handshake. Beats arriving while the FIFO is full (and not
// draining that cycle) are dropped, flagged and counted.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in              : data_intf slave port (valid, data[15:0])
//   out_data        : show-ahead FIFO head, don't-care while out_valid is 0
//   out_valid       : FIFO non-empty
//   out_ready       : consumer takes the head this cycle
//   level           : occupancy, 0..DEPTH
//   overflow        : sticky, a beat was dropped
//   clear_overflow  : synchronous clear of overflow and drop_count
//   drop_count      : saturating count of dropped beats
module data_intf_rx_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_intf.slave                in,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [15:0]    mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  // Full/empty come from the occupancy counter so equal pointers are never
  // ambiguous.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A pop on a full FIFO frees the slot the incoming beat lands in.
  assign pop  = ~empty & out_ready;
  assign push = in.valid & (~full | pop);
  assign drop = in.valid & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as a clear wins: the flag stays set and the
  // count restarts at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in.data;
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = ~empty;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_data_intf_rx_buffer.sv
module tb_data_intf_rx_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic        clear_overflow;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  logic [15:0] sat_out_data;
  logic        sat_out_valid;
  logic [3:0]  sat_level;
  logic        sat_overflow;
  logic [1:0]  sat_drop_count;

  data_intf dif ();

  data_intf_rx_buffer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in             (dif),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  data_intf_rx_buffer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .in             (dif),
    .out_data       (sat_out_data),
    .out_valid      (sat_out_valid),
    .out_ready      (out_ready),
    .level          (sat_level),
    .overflow       (sat_overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (sat_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard state
  logic [15:0] sb_q[$];
  int          sb_pushed;
  int          sb_drops;
  int          sb_seq;
  bit          sb_done;
  bit          sb_rdy;
  bit          sb_v;
  bit          sb_pop;
  bit          sb_acc;
  logic [15:0] sb_d;

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    dif.valid      = 1'b0;
    dif.data       = 16'h0;

    // Reset state
    #3;
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_drop_count", 32'(drop_count), 0);
    #9;
    rst_n = 1'b1;
    step();

    // Basic flow: one-cycle latency, level never above one
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      dif.valid = 1'b1;
      dif.data  = 16'(i);
      step();
      check_eq("flow_valid", 32'(out_valid), 1);
      check_eq("flow_data", 32'(out_data), 32'(i));
      check_eq("flow_level", 32'(level), 1);
    end
    dif.valid = 1'b0;
    step();
    check_eq("flow_empty", 32'(out_valid), 0);
    check_eq("flow_overflow", 32'(overflow), 0);

    // Fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dif.valid = 1'b1;
      dif.data  = 16'hA000 + 16'(i);
      step();
    end
    dif.valid = 1'b0;
    check_eq("ovf_level", 32'(level), 8);
    check_eq("ovf_flag", 32'(overflow), 1);
    check_eq("ovf_drops", 32'(drop_count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_drain_data", 32'(out_data), 32'h0000_A000 + 32'(i));
      step();
    end
    check_eq("ovf_drained", 32'(level), 0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check_eq("ovf_clr_flag", 32'(overflow), 0);
    check_eq("ovf_clr_drops", 32'(drop_count), 0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dif.valid = 1'b1;
      dif.data  = 16'hC000 + 16'(i);
      step();
    end
    check_eq("pp_full", 32'(level), 8);
    out_ready = 1'b1;
    dif.data  = 16'hBEEF;
    step();
    dif.valid = 1'b0;
    check_eq("pp_level", 32'(level), 8);
    check_eq("pp_no_drop", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      check_eq("pp_drain_data", 32'(out_data), 32'h0000_C000 + 32'(i));
      step();
    end
    check_eq("pp_last_beef", 32'(out_data), 32'h0000_BEEF);
    step();
    check_eq("pp_empty", 32'(out_valid), 0);

    // Stall stability
    out_ready = 1'b0;
    dif.valid = 1'b1;
    dif.data  = 16'h1234;
    step();
    dif.valid = 1'b0;
    dif.data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(out_valid), 1);
      check_eq("stall_data", 32'(out_data), 32'h0000_1234);
      step();
    end
    out_ready = 1'b1;
    step();
    check_eq("stall_popped", 32'(level), 0);

    // Pointer wrap over 3*DEPTH accepted beats with random out_ready
    sb_pushed = 0;
    sb_drops  = 0;
    sb_seq    = 0;
    sb_done   = 1'b0;
    for (int cyc = 0; cyc < 400 && !sb_done; cyc++) begin
      sb_rdy = 1'($urandom_range(0, 1));
      sb_v   = (sb_pushed < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      sb_d   = 16'h7000 + 16'(sb_seq);
      out_ready = sb_rdy;
      dif.valid = sb_v;
      dif.data  = sb_d;
      check_eq("sb_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check_eq("sb_level", 32'(level), 32'(sb_q.size()));
      if (sb_q.size() != 0) check_eq("sb_data", 32'(out_data), 32'(sb_q[0]));
      sb_pop = sb_rdy && (sb_q.size() != 0);
      sb_acc = sb_v && ((sb_q.size() < DEPTH) || sb_pop);
      step();
      if (sb_v) sb_seq++;
      if (sb_pop) void'(sb_q.pop_front());
      if (sb_acc) begin
        sb_q.push_back(sb_d);
        sb_pushed++;
      end else if (sb_v) begin
        sb_drops++;
      end
      sb_done = (sb_pushed >= 3 * DEPTH) && (sb_q.size() == 0);
    end
    dif.valid = 1'b0;
    check_eq("sb_finished", 32'(sb_done), 1);
    check_eq("sb_drop_count", 32'(drop_count), 32'(sb_drops));

    // Clear vs drop, and saturation on the narrow counter
    out_ready = 1'b0;
    pulse_reset();
    for (int i = 0; i < 13; i++) begin
      dif.valid = 1'b1;
      dif.data  = 16'hD000 + 16'(i);
      step();
    end
    check_eq("cd_drops5", 32'(drop_count), 5);
    check_eq("sat_drops", 32'(sat_drop_count), 3);
    check_eq("sat_flag", 32'(sat_overflow), 1);
    clear_overflow = 1'b1;
    step();
    check_eq("cd_set_wins_flag", 32'(overflow), 1);
    check_eq("cd_set_wins_cnt", 32'(drop_count), 1);
    dif.valid = 1'b0;
    step();
    clear_overflow = 1'b0;
    check_eq("cd_clear_flag", 32'(overflow), 0);
    check_eq("cd_clear_cnt", 32'(drop_count), 0);

    // Async reset mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    check_eq("ar_level5", 32'(level), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid_now", 32'(out_valid), 0);
    check_eq("ar_level_now", 32'(level), 0);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("ar_idle", 32'(out_valid), 0);
    dif.valid = 1'b1;
    dif.data  = 16'h5A5A;
    step();
    dif.valid = 1'b0;
    check_eq("ar_new_valid", 32'(out_valid), 1);
    check_eq("ar_new_data", 32'(out_data), 32'h0000_5A5A);
    check_eq("ar_new_level", 32'(level), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_intf_rx_buffer.md
# data_intf_rx_buffer

Receive-side buffer for the `data_intf` channel. It samples every beat the producer presents on `data_intf` (`valid`/`data`; the channel has no backpressure) into a small FIFO. It re-presents the beats downstream on a valid/ready handshake, so a consumer that can stall can sit behind a free-running `data_intf` source. Overflow is detected, counted and flagged rather than silently lost.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, ≥2.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in` data_intf interface port: input channel. The block only reads `in.valid` and `in.data[15:0]`.
- `out_data` output 16: FIFO head data.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts the head this cycle.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky flag; a beat was dropped.
- `clear_overflow` input 1: synchronous clear of `overflow` and `drop_count`.
- `drop_count` output CNT_W: number of dropped beats, saturating.

## Operation
- Push: on a rising edge with `in.valid`=1, `in.data` is written if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Pop: on a rising edge with `out_valid`=1 and `out_ready`=1. `out_ready` while empty has no effect.
- Drop: `in.valid`=1, FIFO full, no pop in that cycle. The beat is discarded, `overflow` is set to 1, and `drop_count` increments. `drop_count` saturates at 2^CNT_W−1.
- Push and pop in the same cycle leave `level` unchanged. Push and pop on an empty FIFO is not allowed: the head is not valid before the edge, so only the push occurs.
- Storage is a circular array with read/write pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. Full/empty come from `level` (or an extra pointer bit), never from pointer equality alone.
- `out_data` is show-ahead: a combinational read of the entry at the read pointer. It is don't-care while `out_valid`=0, but must be stable while `out_valid`=1 and `out_ready`=0.
- Ordering is strict FIFO. Accepted beats are never reordered or duplicated.
- `clear_overflow`=1 zeroes `overflow` and `drop_count` at the next edge. If a drop occurs in the same cycle, the set wins: `overflow`=1 and `drop_count`=1.
- `in.data` is ignored when `in.valid`=0.

## Timing
- Reset (async assert, `rst_n`=0): pointers 0, `level`=0, `out_valid`=0, `overflow`=0, `drop_count`=0. `out_data` is undefined. Storage contents are not reset.
- Reset deassertion is synchronized externally. The first push can occur on the first edge with `rst_n`=1.
- Latency: a beat with `in.valid` high before edge N has `out_valid`=1 and that data on `out_data` after edge N, i.e. one cycle of latency.
- Throughput: one push and one pop per cycle, sustained.
- Full: `level`=DEPTH. With `out_ready`=1 every cycle, a continuous `data_intf` stream never overflows, even at DEPTH occupancy.
- `level`, `out_valid`, `overflow` and `drop_count` are registered or derived from registered state only. There is no combinational path from `in` to any output.
- Reset asserted mid-stream: contents are discarded immediately. There is no output activity until new beats arrive after release.

## Test plan
- Basic flow: reset, `out_ready`=1, send 0x0001..0x0010 back-to-back. Expect the same 16 values in order, each one cycle after its input, with `level` ≤1 and `overflow`=0.
- Fill/overflow (DEPTH=8): `out_ready`=0, send 10 beats 0xA000..0xA009. Expect `level`=8, `overflow`=1, `drop_count`=2. Then `out_ready`=1 drains exactly 0xA000..0xA007.
- Full with simultaneous push/pop: fill to 8, then hold `out_ready`=1 and send 0xBEEF. Expect no drop, `level` stays 8, and 0xBEEF emerges last.
- Stall stability: head=0x1234 with `out_ready`=0 for 5 cycles. Expect `out_data`=0x1234 and `out_valid`=1 throughout. Pointers wrap correctly across 3×DEPTH beats with random `out_ready`, checked against a scoreboard.
- Clear vs drop: with `drop_count`=5, assert `clear_overflow` together with a drop. Expect `overflow`=1, `drop_count`=1. Assert `clear_overflow` alone: expect 0/0. Saturation with CNT_W=2: 5 drops → `drop_count`=3.
- Async reset mid-stream: `level`=5, pulse `rst_n` low between edges. Expect `out_valid`=0 and `level`=0 immediately. A new beat 0x5A5A after release is output first.
